// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two per-source FIFOs drained round-robin onto the register-file write port,
// with RAW lookup. Define WB_FWD_EN to add forwarding outputs q_data1/q_data2.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          lsu_valid,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_data,
  output logic          lsu_ready,
  output logic [AW-1:0] write_addr,
  output logic [DW-1:0] write_data,
  output logic          write_ctr,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2,
`ifdef WB_FWD_EN
  output logic [DW-1:0] q_data1,
  output logic [DW-1:0] q_data2,
`endif
  output logic          busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  logic [AW-1:0]    addr_mem [2][DEPTH];
  logic [DW-1:0]    data_mem [2][DEPTH];
  logic [PW-1:0]    wr_ptr   [2];
  logic [PW-1:0]    rd_ptr   [2];
  logic [CW-1:0]    count    [2];
  logic [DEPTH-1:0] entry_valid [2];

  logic [1:0]    in_valid, full, nonempty, push, pop;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic [AW-1:0] q_addr  [2];
  logic [1:0]    hit;

  src_e rr_q, rr_d, winner;
  logic win_valid;

  assign in_valid   = {lsu_valid, alu_valid};
  assign in_addr[0] = alu_addr;
  assign in_addr[1] = lsu_addr;
  assign in_data[0] = alu_data;
  assign in_data[1] = lsu_data;
  assign q_addr[0]  = q_addr1;
  assign q_addr[1]  = q_addr2;

  // Writes to x0 complete the handshake but are dropped before the FIFO.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s]     = count[s] == CW'(DEPTH);
      nonempty[s] = count[s] != '0;
      push[s]     = in_valid[s] && !full[s] && (in_addr[s] != '0);
    end
  end

  assign alu_ready = !full[0];
  assign lsu_ready = !full[1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    winner    = SRC_ALU;
    win_valid = |nonempty;
    rr_d      = rr_q;
    pop       = 2'b00;
    if (&nonempty)        winner = rr_q;
    else if (nonempty[1]) winner = SRC_LSU;
    if (win_valid) begin
      rr_d = (winner == SRC_ALU) ? SRC_LSU : SRC_ALU;
      pop  = (winner == SRC_LSU) ? 2'b10 : 2'b01;
    end
  end

  // NOTE: storage arrays carry no reset; count/rd_ptr decide which entries are meaningful.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        addr_mem[s][wr_ptr[s]] <= in_addr[s];
        data_mem[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      rr_q       <= SRC_ALU;
      write_ctr  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
        count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
      end
      rr_q      <= rr_d;
      write_ctr <= win_valid;
      if (win_valid) begin
        write_addr <= addr_mem[winner][rd_ptr[winner]];
        write_data <= data_mem[winner][rd_ptr[winner]];
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the fill count.
  always_comb begin
    logic [PW-1:0] offset;
    offset = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset            = PW'(i) - rd_ptr[s];
        entry_valid[s][i] = CW'(offset) < count[s];
      end
    end
  end

`ifdef WB_FWD_EN
  logic [DW-1:0] fwd [2];
`endif

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      hit[q] = write_ctr && (write_addr == q_addr[q]);
`ifdef WB_FWD_EN
      fwd[q] = hit[q] ? write_data : '0;
`endif
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entry_valid[s][i] && (addr_mem[s][i] == q_addr[q])) begin
            hit[q] = 1'b1;
`ifdef WB_FWD_EN
            fwd[q] = data_mem[s][i];
`endif
          end
        end
      end
      if (q_addr[q] == '0) begin
        hit[q] = 1'b0;
`ifdef WB_FWD_EN
        fwd[q] = '0;
`endif
      end
    end
  end

  assign q_hit1 = hit[0];
  assign q_hit2 = hit[1];
`ifdef WB_FWD_EN
  assign q_data1 = fwd[0];
  assign q_data2 = fwd[1];
`endif

  assign busy = (|nonempty) || write_ctr;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU (src 0) and load/store unit (src 1).
- Each source has a DEPTH-entry FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs onto registered write-port outputs. These outputs connect directly to the register file's write_addr/write_data/write_ctr.
- Also provides pending-write lookup for two read addresses, so decode can stall on RAW hazards against buffered writebacks.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, 2..8.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_addr  input  AW  ALU destination register.
- alu_data  input  DW  ALU result.
- alu_ready  output  1  ALU FIFO can accept.
- lsu_valid  input  1  LSU writeback request.
- lsu_addr  input  AW  LSU destination register.
- lsu_data  input  DW  load data.
- lsu_ready  output  1  LSU FIFO can accept.
- write_addr  output  AW  to register file write address.
- write_data  output  DW  to register file write data.
- write_ctr  output  1  to register file write enable.
- q_addr1  input  AW  lookup address 1 (rs1).
- q_addr2  input  AW  lookup address 2 (rs2).
- q_hit1  output  1  pending write to q_addr1.
- q_hit2  output  1  pending write to q_addr2.
- busy  output  1  any FIFO non-empty or write_ctr high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - Both FIFOs empty; round-robin pointer = 0 (ALU favoured first).
  - write_addr = 0, write_data = 0, write_ctr = 0; busy = 0.
  - alu_ready and lsu_ready = 1 once reset deasserts.
- Reset mid-operation: all buffered entries are discarded and the outputs return to reset values immediately.
- Handshake:
  - Transfer occurs on a posedge where valid && ready. ready = !full, combinational from FIFO count only.
  - There is no pass-through when full, even if the same cycle dequeues.
  - Inputs must hold stable while valid && !ready.
- x0 filtering: a transfer with addr == 0 is accepted (ready honoured) but not enqueued.
- Arbitration:
  - Performed each cycle on the FIFO heads.
  - Only one head non-empty: that head wins.
  - Both non-empty: the source indicated by the pointer wins. The pointer then toggles to the other source.
  - When exactly one source is served, the pointer is set to the other source.
- Output register:
  - At posedge, if a winner exists, the winner's head is popped and write_addr/write_data load from it, with write_ctr = 1.
  - Otherwise write_ctr = 0 and write_addr/write_data hold their previous values.
  - The register file samples on negedge, mid-cycle, so the outputs are stable.
- Latency and throughput:
  - An entry accepted at posedge k into an empty FIFO, with no contention, drives write_ctr = 1 from posedge k+1 to posedge k+2.
  - Throughput is one write per cycle total.
- Ordering:
  - FIFO order is preserved per source.
  - Cross-source ordering to the same rd is not enforced. Issue stalls while q_hit is set, so at most one pending write per rd exists.
- Simultaneous events: same-cycle push and pop on one FIFO keeps the count unchanged.
- Lookup:
  - q_hitN = 1 if q_addrN != 0 and it matches any valid FIFO entry of either source, or the output register while write_ctr = 1.
  - Combinational, no latency.
- busy: combinational OR of both FIFO non-empty flags and write_ctr.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - Adds outputs q_data1 and q_data2 (DW each).
  - q_dataN gives the data of the single matching pending entry when q_hitN = 1, and 0 otherwise.
  - The output register is included in the match.
  - Decode forwards this data instead of stalling.
- Undefined: the ports are absent and no forwarding mux is built; q_hit behaviour is unchanged.

Test Plan:
- Reset, then an ALU push of addr=5, data=0x1234 at posedge 1 -> write_ctr = 1, write_addr = 5, write_data = 0x1234 during cycle 2 only; busy falls after.
- ALU and LSU both push every cycle (addrs 1..4 and 9..12) -> writes alternate ALU/LSU starting with ALU, and all 8 are written. alu_ready/lsu_ready deassert only when the respective FIFO is full.
- LSU pushes addr=0, data=0xFFFF -> accepted (lsu_ready = 1) with no write_ctr pulse and busy remaining 0.
- LSU FIFO filled with DEPTH = 2 while ALU streams continuously -> lsu_ready = 0 until the first LSU pop; no entry lost or duplicated.
- Hazard lookup: ALU push of addr=7 buffered and q_addr1 = 7 -> q_hit1 = 1 until the write_ctr cycle ends. With WB_FWD_EN, q_data1 equals the pushed data. q_addr2 = 0 -> q_hit2 = 0.
- Assert rst_n low with 3 entries buffered -> write_ctr = 0 and busy = 0 immediately; after release, no stale writes appear.
